led_frame_ctrl: RTL
===================

# led_frame_ctrl

Frame controller between the I2C byte receiver and the LED serial driver. It collects one I2C write transaction of RGB bytes into a back buffer. On a valid STOP it commits the frame to a front buffer and tells the LED driver to load it, but only while the driver is idle. Short, over-long and superseded frames are handled deterministically and reported through sticky error flags.

## Interface
- `LED_CNT`, 3, number of LEDs in the chain; `BYTES` = `LED_CNT`*3, `FW` = `BYTES`*8
- `clk` in 1 — system clock
- `reset` in 1 — asynchronous, active-high reset
- `byte_i` in 8 — received data byte from the I2C slave
- `byte_valid_i` in 1 — one-cycle strobe, `byte_i` valid
- `start_i` in 1 — one-cycle strobe, (repeated) START addressed to us
- `stop_i` in 1 — one-cycle strobe, STOP condition
- `led_busy_i` in 1 — LED driver is shifting out a frame
- `err_clr_i` in 1 — clears `err_o` (synchronous)
- `frame_o` out `FW` — front buffer to the LED driver; reset 0
- `frame_load_o` out 1 — one-cycle pulse, new `frame_o` valid; reset 0
- `rx_active_o` out 1 — high in RECV; reset 0
- `err_o` out 3 — sticky: [0] overflow, [1] short frame, [2] pending frame dropped; reset 0

## Operation
- States:
  - IDLE: waiting for a transaction
  - RECV: collecting bytes
  - PEND: frame complete, waiting for `led_busy_i`=0
- Byte counter `cnt` is `$clog2(BYTES+1)` bits wide and saturates at `BYTES`.
- IDLE:
  - `start_i` sets `cnt`=0 and moves to RECV.
  - `byte_valid_i` and `stop_i` are ignored.
- RECV, `byte_valid_i`:
  - If `cnt`<`BYTES`, write `back[FW-1-8*cnt -: 8]` = `byte_i` and increment `cnt`. Byte 0 is the MSB byte; no bit reversal.
  - Else the byte is discarded and `err_o[0]` is set.
- RECV, `start_i` (repeated start): the partial frame is discarded, `cnt`=0, and the state stays RECV.
- RECV, `stop_i`:
  - If `cnt`==`BYTES`: go to PEND.
  - Else: set `err_o[1]` and go to IDLE; `frame_o` is unchanged.
- PEND:
  - When `led_busy_i`=0: `frame_o`<=back, pulse `frame_load_o`, go to IDLE.
  - When `start_i` arrives: set `err_o[2]`, drop the pending frame, `cnt`=0, go to RECV.
- Simultaneous events:
  - `byte_valid_i` with `stop_i` in RECV: the byte is stored first, then the STOP is evaluated including that byte.
  - `start_i` with `byte_valid_i`: START wins and the byte is dropped.
  - `err_clr_i` with a new error event in the same cycle: the error event wins.
- The back buffer is not reset. Its contents only reach `frame_o` after a full `BYTES` write.

## Timing
- All outputs are registered.
- STOP at cycle N with `led_busy_i`=0 at N+1:
  - State is PEND at N+1.
  - `frame_o` updated and `frame_load_o`=1 at N+2.
  - `frame_load_o` is high for exactly one cycle.
- In PEND, `led_busy_i` falling at cycle M gives `frame_o`/`frame_load_o` at M+1.
- `rx_active_o` rises the cycle after the accepted `start_i` and falls the cycle after `stop_i`.
- `err_o` bits set the cycle after the causing event.
- Asserting `reset` immediately forces:
  - state IDLE, `cnt`=0
  - `frame_o`=0, `frame_load_o`=0, `rx_active_o`=0, `err_o`=0
- Reset applies in any state. A frame received in progress is lost.

## Structure
- Shared package `led_pkg`:
  - state encoding constants `LF_IDLE`, `LF_RECV`, `LF_PEND`
  - error-bit index constants `ERR_OVF`, `ERR_SHORT`, `ERR_DROP`
  - helper function for `BYTES`/`FW` from `LED_CNT`
- Single module, no sub-module. The back buffer, counter and FSM are all local.
- Sits between `i2c` (`data`, `data_valid_o`, `start`, `stop`) and `led` (`data`, plus busy/load handshake).

## Test plan
- **Nominal frame:** `LED_CNT`=3, busy=0, START, bytes 01..09, STOP → `frame_o`=72'h010203040506070809; `frame_load_o` one pulse at STOP+2; `err_o`=0.
- **Short frame:** START, bytes 11,22,33,44, STOP → `frame_o` unchanged, no load pulse, `err_o`=3'b010; `err_clr_i` → 0.
- **Overflow:** START, 11 bytes 01..0B, STOP → `frame_o`=72'h010203040506070809, `err_o[0]`=1, one load pulse.
- **Busy hold:** `led_busy_i`=1 during STOP, released 20 cycles later → `frame_o` held for 20 cycles, load pulse exactly one cycle after release.
- **Repeated start and dropped pending:**
  - START, 3 bytes, START, nine bytes AA, STOP → `frame_o` all AA, `err_o`=0.
  - Then a busy-held PEND followed by a new START → `err_o[2]`=1 and `frame_o` still all AA.
- **Async reset mid-RECV:** pulse `reset` between clock edges after 5 bytes → all outputs 0 with no clock edge; the next full frame loads correctly.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame controller.
// Sizing helpers derive buffer dimensions from the LED count.
package led_pkg;

    typedef enum logic [1:0] {
        LF_IDLE = 2'd0,
        LF_RECV = 2'd1,
        LF_PEND = 2'd2
    } lf_state_e;

    localparam int unsigned ERR_OVF   = 0;
    localparam int unsigned ERR_SHORT = 1;
    localparam int unsigned ERR_DROP  = 2;

    function automatic int unsigned lf_bytes(input int unsigned led_cnt);
        return led_cnt * 3;
    endfunction

    function automatic int unsigned lf_fw(input int unsigned led_cnt);
        return led_cnt * 24;
    endfunction

endpackage

// File: rtl/led_frame_ctrl.sv
// Collects one I2C write of RGB bytes into a back buffer and hands complete
// frames to the LED driver once it is idle; anomalies latch sticky error bits.
module led_frame_ctrl
    import led_pkg::*;
#(
    parameter  int unsigned LED_CNT = 3,
    localparam int unsigned BYTES   = lf_bytes(LED_CNT),
    localparam int unsigned FW      = lf_fw(LED_CNT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          led_busy_i,
    input  logic          err_clr_i,
    output logic [FW-1:0] frame_o,
    output logic          frame_load_o,
    output logic          rx_active_o,
    output logic [2:0]    err_o
);

    localparam int unsigned     CW   = $clog2(BYTES + 1);
    localparam logic [CW-1:0]   FULL = CW'(BYTES);

    lf_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [FW-1:0] back_q, back_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          load_q, load_d;
    logic          rx_q, rx_d;
    logic [2:0]    err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_nxt = cnt_q;
        back_d  = back_q;
        frame_d = frame_q;
        load_d  = 1'b0;
        // Clear first so that an error raised in the same cycle survives.
        err_d   = err_clr_i ? '0 : err_q;

        unique case (state_q)
            LF_IDLE: begin
                if (start_i) begin
                    cnt_d   = '0;
                    state_d = LF_RECV;
                end
            end
            LF_RECV: begin
                if (start_i) begin
                    cnt_d = '0;
                end else begin
                    if (byte_valid_i) begin
                        if (cnt_q < FULL) begin
                            for (int unsigned i = 0; i < BYTES; i++) begin
                                if (cnt_q == CW'(i)) back_d[FW-1-8*i -: 8] = byte_i;
                            end
                            cnt_nxt = cnt_q + CW'(1);
                        end else begin
                            err_d[ERR_OVF] = 1'b1;
                        end
                    end
                    cnt_d = cnt_nxt;
                    // STOP sees the count including a byte arriving alongside it.
                    if (stop_i) begin
                        if (cnt_nxt == FULL) begin
                            state_d = LF_PEND;
                        end else begin
                            err_d[ERR_SHORT] = 1'b1;
                            state_d          = LF_IDLE;
                        end
                    end
                end
            end
            LF_PEND: begin
                if (!led_busy_i) begin
                    frame_d = back_q;
                    load_d  = 1'b1;
                    state_d = LF_IDLE;
                end else if (start_i) begin
                    err_d[ERR_DROP] = 1'b1;
                end
                // A free driver still takes the frame even if a new START lands now.
                if (start_i) begin
                    cnt_d   = '0;
                    state_d = LF_RECV;
                end
            end
            default: state_d = LF_IDLE;
        endcase

        rx_d = (state_d == LF_RECV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LF_IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            load_q  <= 1'b0;
            rx_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            load_q  <= load_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
        end
    end

    // Back buffer is deliberately unreset; only full writes ever reach frame_o.
    always_ff @(posedge clk) begin
        back_q <= back_d;
    end

    assign frame_o      = frame_q;
    assign frame_load_o = load_q;
    assign rx_active_o  = rx_q;
    assign err_o        = err_q;

endmodule
